// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap/non-overlap modes.
// Optional match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               match_q;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   cfg_len_sat;
  logic               hit;

  // Match is judged on the post-shift history/fill so the completing bit counts.
  always_comb begin
    hist_nxt    = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc    = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
    cfg_len_sat = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit = in_valid && !cfg_load && (len_q != '0) && (fill_inc >= len_q) &&
          (((hist_nxt ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q   <= cfg_pattern;
      len_q   <= cfg_len_sat;
      ovl_q   <= cfg_overlap;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (in_valid) begin
        hist_q <= hist_nxt;
        // Non-overlap consumes the completing bit: the next match needs len fresh bits.
        fill_q <= (hit && !ovl_q) ? '0 : fill_inc;
      end
    end
  end

  assign match = match_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
